// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - shared encodings and AXI constants for the 2:1 AXI4 arbiter
package axi_arb_pkg;

    // Arbiter FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;

    // Owner encoding: index of the granted master
    localparam logic OWNER_M0 = 1'b0;   // IFU
    localparam logic OWNER_M1 = 1'b1;   // LSU

    // Transaction kind chosen at grant time
    localparam logic KIND_RD = 1'b0;
    localparam logic KIND_WR = 1'b1;

    // AXI encodings
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_arb_pick.sv
// rtl/axi_arb_pick.sv - winner selection; AXI_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority
module axi_arb_pick
    import axi_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       winner
);

`ifdef AXI_ARB_ROUND_ROBIN_EN
    // On contention hand the grant to whoever did not win last time
    always_comb begin
        winner = OWNER_M0;
        if (req == 2'b11) begin
            winner = ~last_grant;
        end else if (req[1]) begin
            winner = OWNER_M1;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    // LSU always beats IFU
    always_comb begin
        winner = req[1] ? OWNER_M1 : OWNER_M0;
    end
`endif

endmodule

// File: rtl/axi4_arbiter_2to1.sv
// rtl/axi4_arbiter_2to1.sv - two-master to one-slave AXI4 arbiter, one whole transaction per grant
module axi4_arbiter_2to1 #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                clock,
    input  logic                reset,
    // master 0 (IFU)
    input  logic                m0_awvalid,
    input  logic [ADDR_W-1:0]   m0_awaddr,
    input  logic [ID_W-1:0]     m0_awid,
    input  logic [7:0]          m0_awlen,
    input  logic [2:0]          m0_awsize,
    input  logic [1:0]          m0_awburst,
    output logic                m0_awready,
    input  logic                m0_wvalid,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    input  logic                m0_wlast,
    output logic                m0_wready,
    output logic                m0_bvalid,
    output logic [1:0]          m0_bresp,
    output logic [ID_W-1:0]     m0_bid,
    input  logic                m0_bready,
    input  logic                m0_arvalid,
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic [ID_W-1:0]     m0_arid,
    input  logic [7:0]          m0_arlen,
    input  logic [2:0]          m0_arsize,
    input  logic [1:0]          m0_arburst,
    output logic                m0_arready,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [1:0]          m0_rresp,
    output logic                m0_rlast,
    output logic [ID_W-1:0]     m0_rid,
    input  logic                m0_rready,
    // master 1 (LSU)
    input  logic                m1_awvalid,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic [ID_W-1:0]     m1_awid,
    input  logic [7:0]          m1_awlen,
    input  logic [2:0]          m1_awsize,
    input  logic [1:0]          m1_awburst,
    output logic                m1_awready,
    input  logic                m1_wvalid,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wlast,
    output logic                m1_wready,
    output logic                m1_bvalid,
    output logic [1:0]          m1_bresp,
    output logic [ID_W-1:0]     m1_bid,
    input  logic                m1_bready,
    input  logic                m1_arvalid,
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic [ID_W-1:0]     m1_arid,
    input  logic [7:0]          m1_arlen,
    input  logic [2:0]          m1_arsize,
    input  logic [1:0]          m1_arburst,
    output logic                m1_arready,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [1:0]          m1_rresp,
    output logic                m1_rlast,
    output logic [ID_W-1:0]     m1_rid,
    input  logic                m1_rready,
    // slave side toward the SoC crossbar
    output logic                io_master_awvalid,
    output logic [ADDR_W-1:0]   io_master_awaddr,
    output logic [ID_W-1:0]     io_master_awid,
    output logic [7:0]          io_master_awlen,
    output logic [2:0]          io_master_awsize,
    output logic [1:0]          io_master_awburst,
    input  logic                io_master_awready,
    output logic                io_master_wvalid,
    output logic [DATA_W-1:0]   io_master_wdata,
    output logic [DATA_W/8-1:0] io_master_wstrb,
    output logic                io_master_wlast,
    input  logic                io_master_wready,
    input  logic                io_master_bvalid,
    input  logic [1:0]          io_master_bresp,
    input  logic [ID_W-1:0]     io_master_bid,
    output logic                io_master_bready,
    output logic                io_master_arvalid,
    output logic [ADDR_W-1:0]   io_master_araddr,
    output logic [ID_W-1:0]     io_master_arid,
    output logic [7:0]          io_master_arlen,
    output logic [2:0]          io_master_arsize,
    output logic [1:0]          io_master_arburst,
    input  logic                io_master_arready,
    input  logic                io_master_rvalid,
    input  logic [DATA_W-1:0]   io_master_rdata,
    input  logic [1:0]          io_master_rresp,
    input  logic                io_master_rlast,
    input  logic [ID_W-1:0]     io_master_rid,
    output logic                io_master_rready
);

    import axi_arb_pkg::*;

    logic [1:0] state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_grant_q, last_grant_d;
    logic       ar_done_q, ar_done_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;

    logic [1:0] req;
    logic       pick_winner;
    logic       grant_kind;
    logic       rd_act, wr_act, own0, own1;

    assign req    = {m1_arvalid | m1_awvalid, m0_arvalid | m0_awvalid};
    assign rd_act = (state_q == ST_RD);
    assign wr_act = (state_q == ST_WR);
    assign own0   = (owner_q == OWNER_M0);
    assign own1   = (owner_q == OWNER_M1);

    axi_arb_pick u_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .winner     (pick_winner)
    );

    // A winner with both AR and AW pending gets its read first
    assign grant_kind = (pick_winner ? m1_arvalid : m0_arvalid) ? KIND_RD : KIND_WR;

    // Slave-side request channels: owner's signals, zero when the channel is not granted or already handshaken
    always_comb begin
        io_master_arvalid = rd_act & ~ar_done_q & (own1 ? m1_arvalid : m0_arvalid);
        io_master_araddr  = rd_act ? (own1 ? m1_araddr  : m0_araddr)  : '0;
        io_master_arid    = rd_act ? (own1 ? m1_arid    : m0_arid)    : '0;
        io_master_arlen   = rd_act ? (own1 ? m1_arlen   : m0_arlen)   : '0;
        io_master_arsize  = rd_act ? (own1 ? m1_arsize  : m0_arsize)  : '0;
        io_master_arburst = rd_act ? (own1 ? m1_arburst : m0_arburst) : '0;
        io_master_rready  = rd_act & (own1 ? m1_rready : m0_rready);

        io_master_awvalid = wr_act & ~aw_done_q & (own1 ? m1_awvalid : m0_awvalid);
        io_master_awaddr  = wr_act ? (own1 ? m1_awaddr  : m0_awaddr)  : '0;
        io_master_awid    = wr_act ? (own1 ? m1_awid    : m0_awid)    : '0;
        io_master_awlen   = wr_act ? (own1 ? m1_awlen   : m0_awlen)   : '0;
        io_master_awsize  = wr_act ? (own1 ? m1_awsize  : m0_awsize)  : '0;
        io_master_awburst = wr_act ? (own1 ? m1_awburst : m0_awburst) : '0;
        io_master_wvalid  = wr_act & ~w_done_q & (own1 ? m1_wvalid : m0_wvalid);
        io_master_wdata   = wr_act ? (own1 ? m1_wdata : m0_wdata) : '0;
        io_master_wstrb   = wr_act ? (own1 ? m1_wstrb : m0_wstrb) : '0;
        io_master_wlast   = wr_act & (own1 ? m1_wlast : m0_wlast);
        io_master_bready  = wr_act & (own1 ? m1_bready : m0_bready);
    end

    // Master-side readies and responses go to the owner only; the other master sees all zeros
    always_comb begin
        m0_arready = rd_act & own0 & ~ar_done_q & io_master_arready;
        m0_rvalid  = rd_act & own0 & io_master_rvalid;
        m0_rdata   = (rd_act & own0) ? io_master_rdata : '0;
        m0_rresp   = (rd_act & own0) ? io_master_rresp : '0;
        m0_rlast   = rd_act & own0 & io_master_rlast;
        m0_rid     = (rd_act & own0) ? io_master_rid   : '0;
        m0_awready = wr_act & own0 & ~aw_done_q & io_master_awready;
        m0_wready  = wr_act & own0 & ~w_done_q & io_master_wready;
        m0_bvalid  = wr_act & own0 & io_master_bvalid;
        m0_bresp   = (wr_act & own0) ? io_master_bresp : '0;
        m0_bid     = (wr_act & own0) ? io_master_bid   : '0;

        m1_arready = rd_act & own1 & ~ar_done_q & io_master_arready;
        m1_rvalid  = rd_act & own1 & io_master_rvalid;
        m1_rdata   = (rd_act & own1) ? io_master_rdata : '0;
        m1_rresp   = (rd_act & own1) ? io_master_rresp : '0;
        m1_rlast   = rd_act & own1 & io_master_rlast;
        m1_rid     = (rd_act & own1) ? io_master_rid   : '0;
        m1_awready = wr_act & own1 & ~aw_done_q & io_master_awready;
        m1_wready  = wr_act & own1 & ~w_done_q & io_master_wready;
        m1_bvalid  = wr_act & own1 & io_master_bvalid;
        m1_bresp   = (wr_act & own1) ? io_master_bresp : '0;
        m1_bid     = (wr_act & own1) ? io_master_bid   : '0;
    end

    // Grant in IDLE, track handshakes, release on the final response
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        ar_done_d    = ar_done_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        case (state_q)
            ST_IDLE: begin
                ar_done_d = 1'b0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (|req) begin
                    owner_d      = pick_winner;
                    last_grant_d = pick_winner;
                    state_d      = (grant_kind == KIND_RD) ? ST_RD : ST_WR;
                end
            end
            ST_RD: begin
                if (io_master_arvalid & io_master_arready) begin
                    ar_done_d = 1'b1;
                end
                if (io_master_rvalid & io_master_rready & io_master_rlast) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR: begin
                if (io_master_awvalid & io_master_awready) begin
                    aw_done_d = 1'b1;
                end
                if (io_master_wvalid & io_master_wready & io_master_wlast) begin
                    w_done_d = 1'b1;
                end
                if (io_master_bvalid & io_master_bready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWNER_M0;
            last_grant_q <= OWNER_M1;
            ar_done_q    <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            ar_done_q    <= ar_done_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
        end
    end

endmodule
